// File: rtl/lcd_ctrl_param_if.sv
// Host-side bundle for the LCD controller: init config, request strobe/bus,
// and the registered LCD pins plus busy flag.
interface lcd_ctrl_param_if;
  logic [6:0] in_data;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       e;
  logic [7:0] lcd_data;
  logic       rs;
  logic       rw;
  logic       busy;

  modport master (output in_data, lcd_enable, lcd_bus,
                  input  e, lcd_data, rs, rw, busy);
  modport slave  (input  in_data, lcd_enable, lcd_bus,
                  output e, lcd_data, rs, rw, busy);
endinterface

// File: rtl/lcd_ctrl_param.sv
// HD44780-style LCD controller: power-up wait, four-command init, then single
// host writes with fixed E timing. 8-bit or 4-bit bus selected by parameter.
module lcd_ctrl_param #(
  parameter int CLK_FREQ = 30,
  parameter int BUS_4BIT = 0,
  parameter int PWRUP_US = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_ctrl_param_if.slave  lcd
);
  localparam int MAX_US = (PWRUP_US > 440) ? PWRUP_US : 440;
  localparam int W      = $clog2(MAX_US * CLK_FREQ) + 1;
  typedef logic [W-1:0] cnt_t;

  // 4-bit init: 0x2 wake pulse first, and each command is hi pulse, 10 us gap, lo pulse
  localparam int SLOT = (BUS_4BIT != 0) ? 30 : 10;
  localparam int PRE  = (BUS_4BIT != 0) ? 60 : 0;
  localparam int T1   = PRE + SLOT + 50;
  localparam int T2   = T1 + SLOT + 50;
  localparam int T3   = T2 + SLOT + 200;
  localparam int TEND = T3 + SLOT + 100;
  localparam int TSND = (BUS_4BIT != 0) ? 104 : 50;

  localparam cnt_t C_PWR_END  = cnt_t'(PWRUP_US * CLK_FREQ - 1);
  localparam cnt_t C_INIT_END = cnt_t'(TEND * CLK_FREQ - 1);
  localparam cnt_t C_SEND_END = cnt_t'(TSND * CLK_FREQ - 1);
  localparam cnt_t C_T0 = cnt_t'(PRE * CLK_FREQ);
  localparam cnt_t C_T1 = cnt_t'(T1 * CLK_FREQ);
  localparam cnt_t C_T2 = cnt_t'(T2 * CLK_FREQ);
  localparam cnt_t C_T3 = cnt_t'(T3 * CLK_FREQ);
  localparam cnt_t C_1  = cnt_t'(CLK_FREQ);
  localparam cnt_t C_10 = cnt_t'(10 * CLK_FREQ);
  localparam cnt_t C_14 = cnt_t'(14 * CLK_FREQ);
  localparam cnt_t C_20 = cnt_t'(20 * CLK_FREQ);
  localparam cnt_t C_27 = cnt_t'(27 * CLK_FREQ);
  localparam cnt_t C_30 = cnt_t'(30 * CLK_FREQ);
  localparam cnt_t C_54 = cnt_t'(54 * CLK_FREQ);

  typedef enum logic [1:0] {POWERUP, INIT, READY, SEND} state_t;

  state_t     state, nstate;
  cnt_t       cnt, ncnt, base, off;
  logic [9:0] hold, nhold;
  logic [7:0] cmd, nd, data_q;
  logic [3:0] nib;
  logic       ne, nrs, nrw, nbusy, pre;
  logic       e_q, rs_q, rw_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= POWERUP;
      cnt    <= '0;
      hold   <= '0;
      e_q    <= 1'b0;
      data_q <= '0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      hold   <= nhold;
      e_q    <= ne;
      data_q <= nd;
      rs_q   <= nrs;
      rw_q   <= nrw;
      busy_q <= nbusy;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt + cnt_t'(1);
    nhold  = hold;
    case (state)
      POWERUP: if (cnt == C_PWR_END)  begin nstate = INIT;  ncnt = '0; end
      INIT:    if (cnt == C_INIT_END) begin nstate = READY; ncnt = '0; end
      READY: begin
        ncnt = '0;
        if (lcd.lcd_enable) begin
          nstate = SEND;
          nhold  = lcd.lcd_bus;
        end
      end
      SEND:    if (cnt == C_SEND_END) begin nstate = READY; ncnt = '0; end
      default: begin nstate = POWERUP; ncnt = '0; end
    endcase
  end

  if (BUS_4BIT != 0) begin : g_pre
    assign pre = (ncnt < C_T0);
  end else begin : g_nopre
    assign pre = 1'b0;
  end

  // Outputs are decoded from the upcoming state/count so the registers line up
  // with the cycle they describe.
  always_comb begin
    ne    = 1'b0;
    nd    = '0;
    nrs   = 1'b0;
    nrw   = 1'b0;
    nbusy = 1'b1;
    cmd   = '0;
    base  = '0;
    off   = '0;
    nib   = '0;
    case (nstate)
      READY: nbusy = 1'b0;
      INIT: begin
        if (ncnt >= C_T3) begin
          cmd = {6'b000001, lcd.in_data[1:0]}; base = C_T3;
        end else if (ncnt >= C_T2) begin
          cmd = 8'h01; base = C_T2;
        end else if (ncnt >= C_T1) begin
          cmd = {5'b00001, lcd.in_data[4:2]}; base = C_T1;
        end else begin
          cmd = {4'b0011, lcd.in_data[6:5], 2'b00}; base = C_T0;
        end
        off = ncnt - base;
        if (pre) begin
          ne = (ncnt < C_10);
          nd = ne ? 8'h20 : 8'h00;
        end else if (BUS_4BIT != 0) begin
          if (off < C_10) begin
            ne = 1'b1; nd = {cmd[7:4], 4'h0};
          end else if (off >= C_20 && off < C_30) begin
            ne = 1'b1; nd = {cmd[3:0], 4'h0};
          end
        end else begin
          ne = (off < C_10);
          nd = ne ? cmd : 8'h00;
        end
      end
      SEND: begin
        nrs = nhold[9];
        nrw = nhold[8];
        if (BUS_4BIT != 0) begin
          if (ncnt < C_27) begin off = ncnt;        nib = nhold[7:4]; end
          else             begin off = ncnt - C_27; nib = nhold[3:0]; end
          ne = (ncnt < C_54) && (off >= C_1) && (off < C_14);
          nd = {nib, 4'h0};
        end else begin
          ne = (ncnt >= C_1) && (ncnt < C_14);
          nd = nhold[7:0];
        end
      end
      default: ;
    endcase
  end

  assign lcd.e        = e_q;
  assign lcd.lcd_data = data_q;
  assign lcd.rs       = rs_q;
  assign lcd.rw       = rw_q;
  assign lcd.busy     = busy_q;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Runs an 8-bit and a 4-bit controller side by side against a per-cycle
// expected-waveform queue built from the timing rules.
module tb_lcd_ctrl_param;
  localparam int CF  = 2;
  localparam int PUS = 500;

  typedef struct packed {
    logic       busy;
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] d;
  } exp_t;
  typedef exp_t eq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] bus;
  logic [6:0] cfg;
  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  exp_t cur [2];
  exp_t q   [2][$];

  lcd_ctrl_param_if i8 ();
  lcd_ctrl_param_if i4 ();
  assign i8.in_data = cfg;  assign i8.lcd_enable = en;  assign i8.lcd_bus = bus;
  assign i4.in_data = cfg;  assign i4.lcd_enable = en;  assign i4.lcd_bus = bus;

  lcd_ctrl_param #(.CLK_FREQ(CF), .BUS_4BIT(0), .PWRUP_US(PUS)) u8 (.clk(clk), .rst_n(rst_n), .lcd(i8));
  lcd_ctrl_param #(.CLK_FREQ(CF), .BUS_4BIT(1), .PWRUP_US(PUS)) u4 (.clk(clk), .rst_n(rst_n), .lcd(i4));

  always #5 clk = ~clk;

  function automatic exp_t mk(logic b, logic e, logic rs, logic rw, logic [7:0] d);
    exp_t x;
    x.busy = b; x.e = e; x.rs = rs; x.rw = rw; x.d = d;
    return x;
  endfunction

  // Power-up cycles 1.. followed by the init waveform, as a list of timed pulses
  function automatic eq_t build_boot(bit four, logic [6:0] c);
    eq_t q0;
    logic [7:0] cmd [4];
    int wt [4];
    int ps[$], pl[$];
    logic [7:0] pd[$];
    int t;
    exp_t x;
    cmd[0] = {4'b0011, c[6:5], 2'b00};
    cmd[1] = {5'b00001, c[4:2]};
    cmd[2] = 8'h01;
    cmd[3] = {6'b000001, c[1:0]};
    wt[0] = 50; wt[1] = 50; wt[2] = 200; wt[3] = 100;
    t = 0;
    if (four) begin ps.push_back(0); pl.push_back(10); pd.push_back(8'h20); t = 60; end
    for (int i = 0; i < 4; i++) begin
      if (four) begin
        ps.push_back(t);      pl.push_back(10); pd.push_back({cmd[i][7:4], 4'h0});
        ps.push_back(t + 20); pl.push_back(10); pd.push_back({cmd[i][3:0], 4'h0});
        t += 30 + wt[i];
      end else begin
        ps.push_back(t); pl.push_back(10); pd.push_back(cmd[i]);
        t += 10 + wt[i];
      end
    end
    for (int i = 1; i < PUS * CF; i++) q0.push_back(mk(1, 0, 0, 0, 8'h00));
    for (int cy = 0; cy < t * CF; cy++) begin
      x = mk(1, 0, 0, 0, 8'h00);
      for (int j = 0; j < ps.size(); j++)
        if (cy / CF >= ps[j] && cy / CF < ps[j] + pl[j]) begin x.e = 1; x.d = pd[j]; end
      q0.push_back(x);
    end
    return q0;
  endfunction

  function automatic eq_t build_send(bit four, logic [9:0] b);
    eq_t q0;
    int us, ph, o;
    for (int cy = 0; cy < (four ? 104 : 50) * CF; cy++) begin
      us = cy / CF;
      if (!four) q0.push_back(mk(1, (us >= 1 && us < 14), b[9], b[8], b[7:0]));
      else begin
        ph = (us < 27) ? 0 : 1;
        o  = us - 27 * ph;
        q0.push_back(mk(1, (us < 54 && o >= 1 && o < 14), b[9], b[8],
                        ph == 0 ? {b[7:4], 4'h0} : {b[3:0], 4'h0}));
      end
    end
    return q0;
  endfunction

  task automatic rst_assert();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin q[k].delete(); cur[k] = mk(1, 0, 0, 0, 8'h00); end
  endtask

  task automatic rst_release();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) q[k] = build_boot(k == 1, cfg);
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0) cur[k] = q[k].pop_front();
        else if (!cur[k].busy && en) begin
          q[k]   = build_send(k == 1, bus);
          cur[k] = q[k].pop_front();
        end else cur[k] = mk(0, 0, 0, 0, 8'h00);
      end
    end
  end

  task automatic cmp(string nm, exp_t g, exp_t x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s t=%0t got busy/e/rs/rw/data=%b%b%b%b/%h expected %b%b%b%b/%h",
               nm, $time, g.busy, g.e, g.rs, g.rw, g.d, x.busy, x.e, x.rs, x.rw, x.d);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("bus8", mk(i8.busy, i8.e, i8.rs, i8.rw, i8.lcd_data), cur[0]);
      cmp("bus4", mk(i4.busy, i4.e, i4.rs, i4.rw, i4.lcd_data), cur[1]);
    end
  end

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, want);
    end
  endtask

  int n, e8c, e4c, b8c, b4c;
  bit hold_mode;

  initial begin
    en = 0; bus = '0; cfg = 7'h7F;
    rst_assert();
    chk_on = 1;
    repeat (3) @(posedge clk);
    #2 rst_release();
    chk("boot_len8", q[0].size(), 999 + 880);
    chk("boot_len4", q[1].size(), 999 + 1160);

    n = 0;
    while (n < 1100) begin @(posedge clk); #1; n++; if (i8.e) break; end
    chk("first_e_edge", n, 1000);
    chk("fs_data", i8.lcd_data, 8'h3C);
    chk("fs_nib4", i4.lcd_data, 8'h20);
    while (n < 2000) begin @(posedge clk); #1; n++; if (!i8.busy) break; end
    chk("ready8_edge", n, 1880);
    while (n < 2300) begin @(posedge clk); #1; n++; if (!i4.busy) break; end
    chk("ready4_edge", n, 2160);

    @(posedge clk); #2 en = 1; bus = 10'h2A5;
    e8c = 0; e4c = 0; b8c = 0; b4c = 0;
    for (int m = 1; m <= 300; m++) begin
      @(posedge clk); #1;
      if (m == 1) en = 0;
      e8c += int'(i8.e); e4c += int'(i4.e); b8c += int'(i8.busy); b4c += int'(i4.busy);
      if (m == 20) chk("hi_nib", i4.lcd_data, 8'hA0);
      if (m == 80) chk("lo_nib", i4.lcd_data, 8'h50);
      if (m == 50) chk("rs_data8", {i8.rs, i8.rw, i8.lcd_data}, 10'h2A5);
    end
    chk("e8_cycles", e8c, 26);
    chk("e4_cycles", e4c, 52);
    chk("busy8_cycles", b8c, 100);
    chk("busy4_cycles", b4c, 208);

    hold_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (c % 200 == 0) hold_mode = $urandom_range(0, 1) == 1;
      en  = hold_mode ? 1'b1 : ($urandom_range(0, 7) == 0);
      bus = 10'($urandom);
    end

    en = 0;
    n = 0;
    while (n < 300) begin @(posedge clk); #1; n++; if (!i8.busy && !i4.busy) break; end
    chk("idle_before_abort", n < 300 ? 1 : 0, 1);
    @(posedge clk); #2 en = 1; bus = 10'h1C3;
    @(posedge clk); #2 en = 0;
    repeat (10) @(posedge clk);
    #2 rst_assert();
    #1;
    chk("abort_e", i8.e, 0);
    chk("abort_data", i8.lcd_data, 0);
    chk("abort_busy", i8.busy, 1);
    cfg = 7'($urandom);
    repeat (2) @(posedge clk);
    #2 rst_release();
    n = 0;
    while (n < 1100) begin @(posedge clk); #1; n++; if (i8.e) break; end
    chk("reboot_first_e", n, 1000);
    chk("reboot_fs", i8.lcd_data, {4'b0011, cfg[6:5], 2'b00});
    while (n < 2300) begin @(posedge clk); #1; n++; if (!i8.busy && !i4.busy) break; end
    chk("reboot_ready", n, 2160);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      en  = ($urandom_range(0, 3) == 0);
      bus = 10'($urandom);
    end
    en = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl_param.md
LCD_CTRL_PARAM -- requirements
Module: lcd_ctrl_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 30: clk cycles per microsecond; legal range 1..100.
REQ-002 SHALL have parameter BUS_4BIT, default 0: 0 = 8-bit LCD bus, 1 = 4-bit LCD bus.
REQ-003 SHALL have parameter PWRUP_US, default 500: power-up wait in microseconds.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data, input, 7: {lines, font, display_on, cursor, blink, inc_dec, shift}; sampled during init.
REQ-007 SHALL have port lcd_enable, input, 1: host request strobe; accepted only in READY.
REQ-008 SHALL have port lcd_bus, input, 10: {rs, rw, data[7:0]}; captured on accept.
REQ-009 SHALL have port e, output, 1: LCD enable strobe, registered.
REQ-010 SHALL have port lcd_data, output, 8: LCD data, registered; in 4-bit mode the nibble drives [7:4] and [3:0] = 0.
REQ-011 SHALL have ports rs and rw, output, 1 each: LCD register-select and read/write, registered.
REQ-012 SHALL have port busy, output, 1: high whenever a request cannot be accepted.

Function
REQ-013 SHALL implement states POWERUP, INIT, READY, SEND with a single time counter.
- Counter width: $clog2(max(PWRUP_US,440)*CLK_FREQ)+1.
- Microsecond boundaries: N us = N*CLK_FREQ cycles.
REQ-014 POWERUP SHALL hold busy=1, e=0 and count PWRUP_US*CLK_FREQ cycles, then enter INIT with the counter cleared.
REQ-015 INIT SHALL issue four commands. Each command: e=1 with data for 10 us, then e=0 and lcd_data=0 for its wait time.
- Function set {0011, lines, font, 00}: wait 50 us.
- Display control {00001, display_on, cursor, blink}: wait 50 us.
- Clear 0x01: wait 200 us.
- Entry mode {000001, inc_dec, shift}: wait 100 us.
- Transition: at the end of 440 us, enter READY.
- rs = rw = 0 throughout.
REQ-016 When BUS_4BIT=1, INIT SHALL be preceded by a single-nibble 0x2 pulse (e high 10 us, then low 50 us).
- Each 4-bit init command SHALL send the high nibble and then the low nibble, each with e high for 10 us.
- The command's wait time follows the low nibble.
REQ-017 READY SHALL drive busy=0, e=0, rs=0, rw=0, lcd_data=0.
- Accept: lcd_enable=1 captures lcd_bus into holding registers, clears the counter and enters SEND on the next edge.
- busy=1 from that edge onward.
REQ-018 SEND (8-bit) SHALL hold rs, rw and lcd_data at the captured values for the whole state. Timing from entry:
- e=0 for cycles [0, 1 us).
- e=1 for [1 us, 14 us).
- e=0 for [14 us, 50 us).
- Return to READY after 50 us.
REQ-019 SEND (4-bit) SHALL perform two nibble phases of 27 us each, high nibble first.
- Each phase: e=0 for 1 us, e=1 for 13 us, e=0 for 13 us.
- Then hold e=0 for 50 us and return to READY; total 104 us.
- rs and rw are held throughout.
REQ-020 lcd_enable SHALL be ignored in every state other than READY; no request queueing.
REQ-021 A request on the same edge that SEND completes SHALL NOT be accepted; it is acceptable on the first READY cycle.
REQ-022 Counter arithmetic SHALL never wrap: every state clears the counter on exit.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=POWERUP, counter=0, e=0, rs=0, rw=0, lcd_data=0, busy=1.
REQ-024 Reset asserted mid-INIT or mid-SEND SHALL abort immediately. After release, the full power-up and init sequence restarts; no captured request is retained.
REQ-025 The first counting edge SHALL be the first rising clk with rst_n=1.

Verification (CLK_FREQ=2, PWRUP_US=500 unless noted)
REQ-026 Release reset, BUS_4BIT=0, in_data=7'b1111111 -> busy=1 for 1000 cycles, then:
- e=1 with lcd_data=0x3C for 20 cycles.
- Then 0x0F, 0x01, 0x07 pulses at the REQ-015 offsets.
- busy=0 after 880 INIT cycles.
REQ-027 READY, pulse lcd_enable one cycle with lcd_bus=10'h2A5 -> rs=1, rw=0, lcd_data=0xA5 held for 100 cycles; e high during cycles 2..27 of SEND; busy=0 after.
REQ-028 BUS_4BIT=1, lcd_bus=10'h2A5 -> lcd_data[7:4]=0xA during the first 27 us and 0x5 during the second; two e pulses of 26 cycles each; busy high for 208 cycles.
REQ-029 lcd_enable held high continuously in READY -> back-to-back SENDs with one READY cycle (busy=0) between them; lcd_enable during SEND has no effect on the held data.
REQ-030 Assert rst_n=0 at SEND cycle 10 -> on that edge e=0, lcd_data=0, busy=1; after release the 1000-cycle power-up repeats before any init pulse.
